// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP: 16-state FSM, IR, BYPASS/IDCODE/USER data registers.
// Ports: tck/trst(sync, high)/enable, tms/tdi/tdo/tdo_en, state, ir,
// abort_pulse, user_dr_in/out/update. Macro JTAG_USER_DR_EN adds USER DR.
module jtag_tap_param #(
  parameter int IR_WIDTH = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h000FAF01,
  parameter int USER_DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(4'b1110),
  parameter logic [IR_WIDTH-1:0] IR_ABORT = IR_WIDTH'(4'b1000),
  parameter logic [IR_WIDTH-1:0] IR_USER = IR_WIDTH'(4'b1010)
) (
  input  logic tck,
  input  logic trst,
  input  logic enable,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  output logic [3:0] state,
  output logic [IR_WIDTH-1:0] ir,
  output logic abort_pulse,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic user_dr_update
);

  localparam int DRW = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, SEL_IR,
    CAP_DR, CAP_IR, SH_DR, SH_IR,
    EX1_DR, EX1_IR, PAU_DR, PAU_IR,
    EX2_DR, EX2_IR, UPD_DR, UPD_IR
  } tap_e;

  tap_e st;
  tap_e st_nxt;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [DRW-1:0] dr_shift;
  logic [DRW-1:0] dr_nxt;
  logic bypass;
  logic sel_id;
  logic sel_user;

  assign state = st;
  assign sel_id = (ir == IR_IDCODE);

`ifdef JTAG_USER_DR_EN
  logic [USER_DR_WIDTH-1:0] user_q;
  logic upd_q;
  assign sel_user = (ir == IR_USER) && !sel_id;
  assign user_dr_out = user_q;
  assign user_dr_update = upd_q;
`else
  assign sel_user = 1'b0;
  assign user_dr_out = '0;
  assign user_dr_update = 1'b0;
`endif

  always_comb begin
    st_nxt = st;
    unique case (st)
      TLR:    st_nxt = tms ? TLR    : RTI;
      RTI:    st_nxt = tms ? SEL_DR : RTI;
      SEL_DR: st_nxt = tms ? SEL_IR : CAP_DR;
      SEL_IR: st_nxt = tms ? TLR    : CAP_IR;
      CAP_DR: st_nxt = tms ? EX1_DR : SH_DR;
      CAP_IR: st_nxt = tms ? EX1_IR : SH_IR;
      SH_DR:  st_nxt = tms ? EX1_DR : SH_DR;
      SH_IR:  st_nxt = tms ? EX1_IR : SH_IR;
      EX1_DR: st_nxt = tms ? UPD_DR : PAU_DR;
      EX1_IR: st_nxt = tms ? UPD_IR : PAU_IR;
      PAU_DR: st_nxt = tms ? EX2_DR : PAU_DR;
      PAU_IR: st_nxt = tms ? EX2_IR : PAU_IR;
      EX2_DR: st_nxt = tms ? UPD_DR : SH_DR;
      EX2_IR: st_nxt = tms ? UPD_IR : SH_IR;
      UPD_DR: st_nxt = tms ? SEL_DR : RTI;
      UPD_IR: st_nxt = tms ? SEL_DR : RTI;
      default: st_nxt = TLR;
    endcase
  end

  // Shared DR: tdi enters at the MSB of the selected register's width;
  // bits above that width are don't-care.
  always_comb begin
    dr_nxt = dr_shift >> 1;
    if (sel_user) dr_nxt[USER_DR_WIDTH-1] = tdi;
    else dr_nxt[31] = tdi;
  end

  always_comb begin
    tdo_en = (st == SH_DR) || (st == SH_IR);
    tdo = 1'b0;
    if (st == SH_IR) tdo = ir_shift[0];
    else if (st == SH_DR) tdo = (sel_id || sel_user) ? dr_shift[0] : bypass;
  end

  always_ff @(posedge tck) begin
    if (trst) begin
      st <= TLR;
      ir <= IR_IDCODE;
      ir_shift <= '0;
      dr_shift <= '0;
      bypass <= 1'b0;
      abort_pulse <= 1'b0;
`ifdef JTAG_USER_DR_EN
      user_q <= '0;
      upd_q <= 1'b0;
`endif
    end else begin
      abort_pulse <= 1'b0;
`ifdef JTAG_USER_DR_EN
      upd_q <= 1'b0;
`endif
      if (enable) begin
        st <= st_nxt;
        case (st)
          CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
          SH_IR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
          UPD_IR: ir <= ir_shift;
          CAP_DR: begin
            bypass <= 1'b0;
            if (sel_id) dr_shift <= DRW'(IDCODE_VALUE);
            else if (sel_user) dr_shift <= DRW'(user_dr_in);
          end
          SH_DR: begin
            if (sel_id || sel_user) dr_shift <= dr_nxt;
            else bypass <= tdi;
          end
          UPD_DR: begin
            abort_pulse <= (ir == IR_ABORT);
`ifdef JTAG_USER_DR_EN
            if (sel_user) begin
              user_q <= dr_shift[USER_DR_WIDTH-1:0];
              upd_q <= 1'b1;
            end
`endif
          end
          default: ;
        endcase
        // Forcing on entry keeps ir at IDCODE the moment TLR is reached.
        if (st_nxt == TLR) ir <= IR_IDCODE;
      end
    end
  end

endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
- Parametrised IEEE 1149.1-style TAP controller: full 16-state TAP FSM plus real IR and DR shift paths.
- Selectable data registers: BYPASS (1 bit), IDCODE (32 bits) and a USER register of parametrised width, updated in parallel to the core.
- Supersedes the fixed 4-bit-IR, IDCODE-only TAP. Sits between the chip JTAG pins and the debug/user logic.

Parameters:
- IR_WIDTH, 4: instruction register width, minimum 2.
- IDCODE_VALUE, 32'h000FAF01: IDCODE DR content. Bit 0 must be 1.
- USER_DR_WIDTH, 8: USER data register width, minimum 1.
- IR_IDCODE, 4'b1110: IDCODE opcode, zero-extended to IR_WIDTH.
- IR_ABORT, 4'b1000: ABORT opcode, zero-extended to IR_WIDTH.
- IR_USER, 4'b1010: USER opcode, zero-extended to IR_WIDTH.

Ports:
- tck  input  1  sole clock; all logic on posedge.
- trst  input  1  synchronous, active-high reset.
- enable  input  1  when 0, all registers hold.
- tms  input  1  test mode select.
- tdi  input  1  serial data in.
- tdo  output  1  serial data out.
- tdo_en  output  1  high while in Shift-IR or Shift-DR.
- state  output  4  current TAP state, encoded 0..15.
- ir  output  IR_WIDTH  active instruction.
- abort_pulse  output  1  one-cycle pulse.
- user_dr_in  input  USER_DR_WIDTH  parallel value captured into USER DR.
- user_dr_out  output  USER_DR_WIDTH  last updated USER value.
- user_dr_update  output  1  one-cycle pulse when user_dr_out changes.

Behaviour:
- Interface: one clock, tck. Reset trst is synchronous and active-high.
- Reset (trst=1 at posedge), taking priority over enable:
  - state=0 (TestLogicReset), ir=IR_IDCODE, shift registers=0.
  - tdo=0, tdo_en=0, abort_pulse=0, user_dr_out=0, user_dr_update=0.
- State encoding: 0 TLR, 1 RTI, 2 SelDR, 3 SelIR, 4 CapDR, 5 CapIR, 6 ShDR, 7 ShIR, 8 Ex1DR, 9 Ex1IR, 10 PauDR, 11 PauIR, 12 Ex2DR, 13 Ex2IR, 14 UpdDR, 15 UpdIR.
- Transitions follow IEEE 1149.1 exactly, including SelIR + tms=1 -> TLR. No data-dependent exits: leaving ShDR depends only on tms.
- Five consecutive enabled cycles with tms=1 reach TLR from any state.
- In TLR: ir forced to IR_IDCODE every cycle.
- enable=0: state, shift registers, ir, user_dr_out all hold; tdo holds; pulses forced to 0.
- IR path:
  - CapIR: ir_shift <= {0..., 2'b01}.
  - ShIR: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
  - UpdIR: ir <= ir_shift.
- DR select, decoded from ir:
  - IR_IDCODE -> IDCODE register (32 bits).
  - IR_USER -> USER register.
  - Any other value, including IR_ABORT and all-ones, -> BYPASS.
- DR capture at CapDR:
  - IDCODE: dr_shift <= IDCODE_VALUE.
  - BYPASS: bypass bit <= 0.
  - USER: dr_shift <= user_dr_in.
- ShDR: selected register shifts right with tdi into its MSB. The shift width is the selected register's width (1, 32 or USER_DR_WIDTH).
- tdo: combinational from the selected register's LSB (IR LSB in ShIR) while tdo_en=1, else 0.
  - Each bit is valid between posedges; the bench samples at the next posedge.
  - Data is LSB first; the bit shifted in at a posedge appears after the register's width of ShDR cycles.
- UpdDR:
  - USER selected: user_dr_out <= dr_shift[USER_DR_WIDTH-1:0]; user_dr_update=1 for that cycle only.
  - ABORT selected: abort_pulse=1 for that cycle only.
  - IDCODE update has no effect.
- Pause/Exit states: shift registers hold. Re-entering Shift from Ex2 continues without recapture.
- trst mid-shift: partial shift discarded, user_dr_out cleared to 0, no update pulse.

Optional Feature:
- Macro: JTAG_USER_DR_EN.
- Defined: USER register and IR_USER decode are present as above.
- Undefined:
  - IR_USER decodes as BYPASS.
  - user_dr_out is tied to 0; user_dr_update is tied to 0; user_dr_in is ignored.
  - Port list is unchanged.

Test Plan:
- IDCODE readout: trst 1 cycle, then tms 0,1,0,0, then 32 cycles of tms=0 (last with tms=1) -> tdo LSB-first reads 0x000FAF01; state=8 after the last bit.
- IR capture/load: from RTI, tms 1,1,0,0 to ShIR; shift tdi 1,1,1,1 (last with tms=1), tms 1 -> tdo first reads 1,0,0,0; at UpdIR ir=4'b1111.
- Bypass: ir=4'b1111, ShDR with tdi 1,0,1,1 -> tdo 0,1,0,1 (one-bit delay, leading 0).
- USER round trip: ir=IR_USER, user_dr_in=0xA5, shift in 0x3C -> tdo reads 0xA5 LSB-first; at UpdDR, user_dr_update pulses once and user_dr_out=0x3C. With the macro off -> bypass behaviour and user_dr_out stays 0.
- ABORT and TMS reset: ir=IR_ABORT, pass through UpdDR -> abort_pulse high exactly 1 cycle. Then from ShDR, 5 cycles of tms=1 -> state=0 and ir=IR_IDCODE.
- Enable/reset:
  - enable=0 for 10 cycles mid-ShDR with tms toggling -> state and tdo unchanged.
  - trst mid-USER-shift -> state=0, user_dr_out=0, no update pulse.
